// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the serial word receiver.
// RX_PARITY_EN (optional macro) enables the trailing even-parity bit per frame.
package sipo_rx_pkg;

  typedef enum logic {
    SHIFT  = 1'b0,
    PARITY = 1'b1
  } rx_state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rx_word_holding_reg.sv
// Holding register with valid/ready handshake and sticky overrun flag.
// RX_PARITY_EN adds a parity-error bit that travels with the held word.
module rx_word_holding_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  word_done,
  input  logic [DATA_WIDTH-1:0] word,
`ifdef RX_PARITY_EN
  input  logic                  parity_err_in,
  output logic                  parity_error,
`endif
  input  logic                  ready,
  input  logic                  overrun_clear,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  overrun
);

  logic load;
  logic drop;

  // A completed word may replace the held one only if that one leaves this cycle.
  assign load = word_done & (~valid | ready);
  assign drop = word_done & valid & ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
`ifdef RX_PARITY_EN
      parity_error <= 1'b0;
`endif
    end else if (load) begin
      data  <= word;
      valid <= 1'b1;
`ifdef RX_PARITY_EN
      parity_error <= parity_err_in;
`endif
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (overrun_clear) overrun <= 1'b0;
  end

endmodule

// File: rtl/sipo_word_receiver.sv
// Serial-to-parallel word receiver: bit assembly FSM feeding a holding register.
// RX_PARITY_EN adds a PARITY state and the Parity_Error_Out port.
module sipo_word_receiver
  import sipo_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                                 Clk_In,
  input  logic                                 Reset_In,
  input  logic                                 Enable_In,
  input  logic                                 Shift_Data_Signal_In,
  input  logic                                 Serial_Data_In,
  input  logic                                 Frame_Start_In,
  input  logic                                 Data_Ready_In,
  input  logic                                 Overrun_Clear_In,
  output logic [DATA_WIDTH-1:0]                Parallel_Data_Out,
  output logic                                 Data_Valid_Out,
  output logic                                 Overrun_Out,
`ifdef RX_PARITY_EN
  output logic                                 Parity_Error_Out,
`endif
  output logic [cnt_width(DATA_WIDTH)-1:0]     Bit_Count_Out
);

  localparam int unsigned CW = cnt_width(DATA_WIDTH);

  rx_state_t             state;
  logic [CW-1:0]         bit_count;
  logic [DATA_WIDTH-1:0] assembly;
  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  accepted;
  logic                  resync;
  logic                  last_data;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word;

  assign accepted  = Enable_In & Shift_Data_Signal_In;
  assign resync    = Enable_In & Frame_Start_In;
  assign last_data = accepted & ~resync & (state == SHIFT) &
                     (bit_count == CW'(DATA_WIDTH - 1));

  // Resync shifts into a cleared register, so the strobed bit becomes bit 0 of a new frame.
  always_comb begin
    base = resync ? '0 : assembly;
    if (MSB_FIRST) shifted = {base[DATA_WIDTH-2:0], Serial_Data_In};
    else           shifted = {Serial_Data_In, base[DATA_WIDTH-1:1]};
  end

`ifdef RX_PARITY_EN
  logic parity_err;
  assign word_done  = accepted & ~resync & (state == PARITY);
  assign word       = assembly;
  assign parity_err = ^assembly ^ Serial_Data_In;
`else
  assign word_done  = last_data;
  assign word       = shifted;
`endif

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state     <= SHIFT;
      bit_count <= '0;
      assembly  <= '0;
    end else if (resync) begin
      state     <= SHIFT;
      assembly  <= accepted ? shifted : '0;
      bit_count <= accepted ? CW'(1) : '0;
    end else if (accepted) begin
      case (state)
        SHIFT: begin
          assembly <= shifted;
          if (last_data) begin
`ifdef RX_PARITY_EN
            bit_count <= CW'(DATA_WIDTH);
            state     <= PARITY;
`else
            bit_count <= '0;
`endif
          end else begin
            bit_count <= bit_count + 1'b1;
          end
        end
        default: begin
          bit_count <= '0;
          state     <= SHIFT;
        end
      endcase
    end
  end

  assign Bit_Count_Out = bit_count;

  rx_word_holding_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk           (Clk_In),
    .rst           (Reset_In),
    .word_done     (word_done),
    .word          (word),
`ifdef RX_PARITY_EN
    .parity_err_in (parity_err),
    .parity_error  (Parity_Error_Out),
`endif
    .ready         (Data_Ready_In),
    .overrun_clear (Overrun_Clear_In),
    .data          (Parallel_Data_Out),
    .valid         (Data_Valid_Out),
    .overrun       (Overrun_Out)
  );

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Directed bench driving an MSB-first and an LSB-first receiver from one bit stream.
// Honours RX_PARITY_EN by appending an even-parity bit to every frame.
module tb_sipo_word_receiver;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst, en, strobe, sdata, fs, ready, oclr;
  logic [W-1:0]  data_m, data_l;
  logic          valid_m, valid_l, ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;
`ifdef RX_PARITY_EN
  logic perr_m, perr_l;
`endif

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  logic [W-1:0] q_m[$];
  logic [W-1:0] q_l[$];

  always #5 clk = ~clk;

  sipo_word_receiver #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Shift_Data_Signal_In(strobe),
    .Serial_Data_In(sdata), .Frame_Start_In(fs), .Data_Ready_In(ready),
    .Overrun_Clear_In(oclr), .Parallel_Data_Out(data_m), .Data_Valid_Out(valid_m),
    .Overrun_Out(ovr_m),
`ifdef RX_PARITY_EN
    .Parity_Error_Out(perr_m),
`endif
    .Bit_Count_Out(cnt_m)
  );

  sipo_word_receiver #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Shift_Data_Signal_In(strobe),
    .Serial_Data_In(sdata), .Frame_Start_In(fs), .Data_Ready_In(ready),
    .Overrun_Clear_In(oclr), .Parallel_Data_Out(data_l), .Data_Valid_Out(valid_l),
    .Overrun_Out(ovr_l),
`ifdef RX_PARITY_EN
    .Parity_Error_Out(perr_l),
`endif
    .Bit_Count_Out(cnt_l)
  );

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_bit(input logic b, input logic f);
    @(negedge clk);
    sdata = b; strobe = 1'b1; fs = f;
    tick();
    strobe = 1'b0; fs = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) strobe_bit(v[i], 1'b0);
  endtask

  task automatic send_parity(input logic [W-1:0] v);
`ifdef RX_PARITY_EN
    strobe_bit(^v, 1'b0);
`else
    if (v === 'x) $error("FAIL send_parity observed=x expected=known");
`endif
  endtask

  task automatic send_word(input logic [W-1:0] v);
    send_bits(v, W - 1, 0);
    send_parity(v);
  endtask

  task automatic push_word(input logic [W-1:0] v);
    q_m.push_back(v);
    q_l.push_back(rev(v));
  endtask

  task automatic expect_word(input string tag);
    logic [W-1:0] em, el;
    chk({tag, "_sb_nonempty"}, 64'(q_m.size() != 0 && q_l.size() != 0), 64'd1);
    em = (q_m.size() != 0) ? q_m.pop_front() : '0;
    el = (q_l.size() != 0) ? q_l.pop_front() : '0;
    chk({tag, "_valid_m"}, 64'(valid_m), 64'd1);
    chk({tag, "_data_m"},  64'(data_m),  64'(em));
    chk({tag, "_valid_l"}, 64'(valid_l), 64'd1);
    chk({tag, "_data_l"},  64'(data_l),  64'(el));
    chk({tag, "_cnt_m"},   64'(cnt_m),   64'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; strobe = 1'b0; sdata = 1'b0; fs = 1'b0; ready = 1'b0; oclr = 1'b0;
    #1;
    chk("rst_data",  64'(data_m),  64'd0);
    chk("rst_valid", 64'(valid_m), 64'd0);
    chk("rst_ovr",   64'(ovr_m),   64'd0);
    chk("rst_cnt",   64'(cnt_m),   64'd0);
    tick(); tick();
    @(negedge clk); rst = 1'b0;

    // Basic MSB-first word, then handshake clears valid.
    ready = 1'b1;
    push_word(32'hA5A5F00F);
    send_word(32'hA5A5F00F);
    expect_word("w1");
    tick();
    chk("w1_valid_clr", 64'(valid_m), 64'd0);

    // Single bit sent first: LSB-first instance reads 1, MSB-first reads 0x80000000.
    push_word(32'h80000000);
    send_word(32'h80000000);
    expect_word("w2");
    tick();

    // Back-to-back words with no consumer: second is dropped.
    ready = 1'b0;
    push_word(32'h11112222);
    send_word(32'h11112222);
    expect_word("ov1");
    send_word(32'h33334444);
    chk("ov_hold_m", 64'(data_m), 64'h11112222);
    chk("ov_flag_m", 64'(ovr_m),  64'd1);
    chk("ov_flag_l", 64'(ovr_l),  64'd1);
    @(negedge clk); oclr = 1'b1;
    tick(); oclr = 1'b0;
    chk("ov_clr",      64'(ovr_m),   64'd0);
    chk("ov_clr_hold", 64'(data_m),  64'h11112222);
    chk("ov_clr_vld",  64'(valid_m), 64'd1);
    ready = 1'b1;
    tick();
    chk("ov_drain", 64'(valid_m), 64'd0);

    // New word loads in the same cycle the held one is accepted: no overrun.
    ready = 1'b0;
    push_word(32'h0F0F1234);
    send_word(32'h0F0F1234);
    expect_word("sim1");
`ifdef RX_PARITY_EN
    send_bits(32'hCAFE0001, W - 1, 0);
    ready = 1'b1;
    send_parity(32'hCAFE0001);
`else
    send_bits(32'hCAFE0001, W - 1, 1);
    ready = 1'b1;
    strobe_bit(1'b1, 1'b0);
`endif
    push_word(32'hCAFE0001);
    expect_word("sim2");
    chk("sim_no_ovr", 64'(ovr_m), 64'd0);
    tick();

    // Asynchronous reset mid-frame.
    send_bits(32'hFFFFFFFF, W - 1, W - 10);
    chk("pre_rst_cnt", 64'(cnt_m), 64'd10);
    @(negedge clk); rst = 1'b1;
    #2;
    chk("async_rst_cnt", 64'(cnt_m), 64'd0);
    rst = 1'b0;
    push_word(32'h12345678);
    send_word(32'h12345678);
    expect_word("after_rst");
    tick();

    // Frame resync on the 11th strobe.
    send_bits(32'hFFFFFFFF, W - 1, W - 10);
    strobe_bit(1'b0, 1'b1);  // bit 31 of 0x12345678 with frame start
    chk("fs_cnt", 64'(cnt_m), 64'd1);
    send_bits(32'h12345678, W - 2, 0);
    send_parity(32'h12345678);
    push_word(32'h12345678);
    expect_word("after_fs");
    tick();

    // Enable low mid-frame freezes counting.
    send_bits(32'hDEADBEEF, W - 1, 16);
    en = 1'b0;
    for (int i = 0; i < 5; i++) strobe_bit(1'($urandom_range(0, 1)), 1'b0);
    chk("en_cnt_m", 64'(cnt_m), 64'd16);
    chk("en_cnt_l", 64'(cnt_l), 64'd16);
    en = 1'b1;
    send_bits(32'hDEADBEEF, 15, 0);
    send_parity(32'hDEADBEEF);
    push_word(32'hDEADBEEF);
    expect_word("en_word");
    tick();

`ifdef RX_PARITY_EN
    send_bits(32'h00000003, W - 1, 0);
    strobe_bit(1'b1, 1'b0);
    push_word(32'h00000003);
    expect_word("par1");
    chk("par1_err_m", 64'(perr_m), 64'd1);
    chk("par1_err_l", 64'(perr_l), 64'd1);
    tick();
    send_bits(32'h00000003, W - 1, 0);
    strobe_bit(1'b0, 1'b0);
    push_word(32'h00000003);
    expect_word("par0");
    chk("par0_err_m", 64'(perr_m), 64'd0);
    chk("par0_err_l", 64'(perr_l), 64'd0);
    tick();
`endif

    chk("sb_drained", 64'(q_m.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
